// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples BCLK/LRC/DAT on in_clk, deserialises MSB-first slots,
// and reports completed samples, short slots and loss of bit clock.
module i2s_rx #(
    parameter int BPS          = 24,
    parameter int TIMEOUT_CLKS = 256
) (
    input  logic           in_clk,
    input  logic           in_reset,
    input  logic           in_BCLK,
    input  logic           in_LRC,
    input  logic           in_DAT,
    output logic [BPS-1:0] out_sample,
    output logic           out_channel,
    output logic           out_ready,
    output logic           out_frame_error,
    output logic           out_locked
);

    localparam int CW = $clog2(BPS + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT
    } state_t;

    state_t         r_state;
    logic           r_bclk_m;
    logic           r_bclk_s;
    logic           r_bclk_d;
    logic           r_lrc_m;
    logic           r_lrc_s;
    logic           r_dat_m;
    logic           r_dat_s;
    logic           r_lrc_prev;
    logic           r_slot_ch;
    logic [BPS-2:0] r_shift;
    logic [CW-1:0]  r_cnt;
    logic [TW-1:0]  r_to_cnt;

    logic           w_bclk_rise;
    logic           w_lrc_chg;
    logic           w_last_bit;
    logic           w_timeout;
    logic [BPS-1:0] w_shifted;

    assign w_bclk_rise = r_bclk_s & ~r_bclk_d;
    assign w_lrc_chg   = r_lrc_s != r_lrc_prev;
    assign w_last_bit  = (r_cnt == CW'(BPS - 1));
    assign w_timeout   = (r_to_cnt == TW'(TIMEOUT_CLKS));
    assign w_shifted   = {r_shift, r_dat_s};

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_state         <= ST_IDLE;
            r_bclk_m        <= 1'b0;
            r_bclk_s        <= 1'b0;
            r_bclk_d        <= 1'b0;
            r_lrc_m         <= 1'b0;
            r_lrc_s         <= 1'b0;
            r_dat_m         <= 1'b0;
            r_dat_s         <= 1'b0;
            r_lrc_prev      <= 1'b0;
            r_slot_ch       <= 1'b0;
            r_shift         <= '0;
            r_cnt           <= '0;
            r_to_cnt        <= '0;
            out_sample      <= '0;
            out_channel     <= 1'b0;
            out_ready       <= 1'b0;
            out_frame_error <= 1'b0;
            out_locked      <= 1'b0;
        end else begin
            r_bclk_m        <= in_BCLK;
            r_bclk_s        <= r_bclk_m;
            r_bclk_d        <= r_bclk_s;
            r_lrc_m         <= in_LRC;
            r_lrc_s         <= r_lrc_m;
            r_dat_m         <= in_DAT;
            r_dat_s         <= r_dat_m;
            out_ready       <= 1'b0;
            out_frame_error <= 1'b0;
            out_locked      <= (r_state == ST_SHIFT) || (r_state == ST_WAIT);

            if (w_bclk_rise) begin
                r_to_cnt   <= '0;
                r_lrc_prev <= r_lrc_s;
                case (r_state)
                    ST_IDLE: begin
                        if (w_lrc_chg) begin
                            r_state   <= ST_SHIFT;
                            r_cnt     <= '0;
                            r_slot_ch <= r_lrc_s;
                        end
                    end
                    ST_SHIFT: begin
                        r_shift <= w_shifted[BPS-2:0];
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last_bit) begin
                            out_sample  <= w_shifted;
                            out_channel <= r_slot_ch;
                            out_ready   <= 1'b1;
                        end
                        // The LRC edge arrives with the slot's final bit, so an exact
                        // BPS-bit slot completes and restarts on the same edge.
                        if (w_lrc_chg) begin
                            out_frame_error <= ~w_last_bit;
                            r_state         <= ST_SHIFT;
                            r_cnt           <= '0;
                            r_slot_ch       <= r_lrc_s;
                        end else if (w_last_bit) begin
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (w_lrc_chg) begin
                            r_state   <= ST_SHIFT;
                            r_cnt     <= '0;
                            r_slot_ch <= r_lrc_s;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_timeout) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule
